alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single ALU (operand registers plus the 4-bit result-select mux) between two requesters, e.g. the execute stage and the address/PC-increment path.
- Arbitrates round-robin and registers operands and select onto the ALU inputs.
- Holds those inputs for the operation's latency, captures the result, and returns it to the winning requester over a valid/ready response handshake.

Parameters:
- WIDTH, 32, operand/result width
- SEL_W, 4, ALU select width
- MAX_SEL, 9, highest legal select code (mux inputs 0..9)
- SLOW_SEL, 8, select codes >= SLOW_SEL are multi-cycle
- SLOW_LAT, 3, ALU cycles for slow ops (>= 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_sel  in  SEL_W  requested ALU select
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 takes result
- resp0_result  out  WIDTH  result
- resp0_err  out  1  illegal select
- req1_*, resp1_*  same as requester 0
- alu_a  out  WIDTH  registered ALU operand A
- alu_b  out  WIDTH  registered ALU operand B
- alu_sel  out  SEL_W  registered ALU mux select
- alu_result  in  WIDTH  ALU mux output
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; all outputs 0; cycle counter=0; last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation aborts: no response is ever issued for the in-flight op.
- States: IDLE, EXEC, RESP.
- IDLE, winner selection:
  - winner = only valid requester; if both valid, winner = requester != last_grant.
  - reqN_ready is combinational: 1 only in IDLE and only for the winner.
  - Ready never depends on resp signals.
- IDLE, handshake (reqN_valid & reqN_ready at edge T):
  - Latch owner=N, alu_a/alu_b/alu_sel from requester N.
  - sel > MAX_SEL: skip EXEC; go RESP with result=0, err=1. resp valid at T+1.
  - sel < SLOW_SEL: counter=0, go EXEC.
  - sel >= SLOW_SEL: counter=SLOW_LAT-1, go EXEC.
- IDLE with no valid request: alu_* hold their previous values.
- EXEC:
  - alu_a/b/sel stay stable.
  - If counter==0: capture alu_result into respN_result, err=0, go RESP.
  - Else decrement counter.
- Latency, measured from handshake edge T to respN_valid high:
  - fast op: T+2
  - slow op: T+SLOW_LAT+1
  - illegal select: T+1
- RESP:
  - respN_valid=1 for the owner only; the other resp_valid stays 0.
  - result/err are held until respN_ready.
  - On respN_valid & respN_ready: deassert valid, last_grant=owner, go IDLE.
  - Next grant is possible the cycle after the response handshake, giving at most one op in flight.
- A requester may drop valid before ready without penalty. Its held request is not guaranteed.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1.
- A requester with its response pending is not blocked from requesting again. It re-enters arbitration normally once IDLE is reached.
- Results are passed through unmodified at full WIDTH; no arithmetic is done in this block.

Test Plan:
- Reset then req0 only: sel=0, a=0xABCDEFAB, b=0x0F0F0F0F, ALU model returns a -> req0_ready at cycle 1, alu_sel=0 next cycle, resp0_valid 2 cycles after handshake with resp0_result=0xABCDEFAB, err=0; resp1_valid stays 0.
- Both requesters valid every cycle: req0 sel=1, req1 sel=1, resp_ready tied 1 -> grant order 0,1,0,1; each response carries that requester's operands' result.
- Slow op: req1 sel=8, ALU model returns 0xFFFFFFFF -> resp1_valid exactly SLOW_LAT+1=4 cycles after handshake; alu_sel held at 8 throughout EXEC; busy high from T+1 until the response handshake.
- Illegal select: req0 sel=12 -> resp0_valid at T+1 with result=0, err=1; ALU inputs not updated.
- Back-pressure: resp0_ready held 0 for 5 cycles while req1 valid -> result stable, req1_ready stays 0; req1 granted the cycle after resp0 handshake.
- rst_n low during EXEC of a slow op -> next cycle all outputs 0, state IDLE, no resp issued; req0 wins the next tie.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. It registers
// the operands and select, holds them for the op latency, and returns the result.
module alu_arbiter #(
   parameter int WIDTH    = 32,
   parameter int SEL_W    = 4,
   parameter int MAX_SEL  = 9,
   parameter int SLOW_SEL = 8,
   parameter int SLOW_LAT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [SEL_W-1:0] req0_sel,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [WIDTH-1:0] resp0_result,
   output logic             resp0_err,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [SEL_W-1:0] req1_sel,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp1_result,
   output logic             resp1_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   output logic             busy
);

   localparam int CNT_W = $clog2(SLOW_LAT);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               last_grant;
   logic               owner;
   logic               grant;
   logic               hs;
   logic [SEL_W-1:0]   hs_sel;
   logic [WIDTH-1:0]   hs_a;
   logic [WIDTH-1:0]   hs_b;
   logic [WIDTH-1:0]   result;
   logic               err;
   logic               resp_take;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high. Request ready depends only on state and the request valids;
   // response valid is held, with stable data, until the requester's ready.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else
         grant = req1_valid;
   end

   assign req0_ready = (state == IDLE) && req0_valid && !grant;
   assign req1_ready = (state == IDLE) && req1_valid && grant;
   assign hs         = req0_ready || req1_ready;
   assign hs_sel     = grant ? req1_sel : req0_sel;
   assign hs_a       = grant ? req1_a   : req0_a;
   assign hs_b       = grant ? req1_b   : req0_b;
   assign resp_take  = owner ? resp1_ready : resp0_ready;

   assign resp0_result = result;
   assign resp1_result = result;
   assign resp0_err    = err;
   assign resp1_err    = err;
   assign busy         = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_sel     <= '0;
         result      <= '0;
         err         <= 1'b0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hs) begin
                  owner <= grant;
                  // Illegal selects never reach the mux, so the ALU inputs keep their old values.
                  if (hs_sel > SEL_W'(MAX_SEL)) begin
                     result      <= '0;
                     err         <= 1'b1;
                     resp0_valid <= !grant;
                     resp1_valid <= grant;
                     state       <= RESP;
                  end else begin
                     alu_a   <= hs_a;
                     alu_b   <= hs_b;
                     alu_sel <= hs_sel;
                     cnt     <= (hs_sel >= SEL_W'(SLOW_SEL)) ? CNT_W'(SLOW_LAT - 1) : '0;
                     state   <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  result      <= alu_result;
                  err         <= 1'b0;
                  resp0_valid <= !owner;
                  resp1_valid <= owner;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_take) begin
                  resp0_valid <= 1'b0;
                  resp1_valid <= 1'b0;
                  last_grant  <= owner;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
